// File: rtl/encoder_pkg.sv
// Shared encoder definitions: dir step codes, motion state encodings and step decode.
package encoder_pkg;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_REV  = 2'b01;
  localparam logic [1:0] DIR_FWD  = 2'b10;
  localparam logic [1:0] DIR_ILL  = 2'b11;

  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    FWD     = 2'b01,
    REV     = 2'b10
  } motion_t;

  // Illegal codes decode to no movement; the caller flags them separately.
  function automatic logic signed [1:0] dir_to_step(input logic [1:0] d);
    logic signed [1:0] s;
    case (d)
      DIR_FWD: s = 2'sb01;
      DIR_REV: s = 2'sb11;
      default: s = 2'sb00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/enc_vel_window.sv
// Velocity sampler: counts signed steps over a fixed WINDOW-cycle window and
// publishes the saturated total with a one-cycle vel_valid strobe.
module enc_vel_window
  import encoder_pkg::*;
#(
  parameter int VEL_W  = 12,
  parameter int WINDOW = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [1:0]       step,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid
);

  localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  logic [CNT_W-1:0]        r_win_cnt;
  logic signed [VEL_W-1:0] r_acc;
  logic signed [VEL_W-1:0] r_vel;
  logic                    r_vel_valid;
  logic signed [VEL_W-1:0] w_acc_next;
  logic                    w_last;

  // One-bit headroom add; a sign mismatch between the top two bits means overflow.
  function automatic logic signed [VEL_W-1:0] sat_add(
    input logic signed [VEL_W-1:0] a,
    input logic signed [1:0]       s
  );
    logic signed [VEL_W:0] sum;
    sum = {a[VEL_W-1], a} + {{(VEL_W-1){s[1]}}, s};
    if (sum[VEL_W] != sum[VEL_W-1])
      return sum[VEL_W] ? {1'b1, {(VEL_W-1){1'b0}}} : {1'b0, {(VEL_W-1){1'b1}}};
    else
      return sum[VEL_W-1:0];
  endfunction

  assign w_last     = (r_win_cnt == CNT_LAST);
  assign w_acc_next = sat_add(r_acc, step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt   <= '0;
      r_acc       <= '0;
      r_vel       <= '0;
      r_vel_valid <= 1'b0;
    end else begin
      r_vel_valid <= w_last;
      if (w_last) begin
        r_win_cnt <= '0;
        r_acc     <= '0;
        r_vel     <= w_acc_next;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
        r_acc     <= w_acc_next;
      end
    end
  end

  assign vel       = r_vel;
  assign vel_valid = r_vel_valid;

endmodule

// File: rtl/encoder_position.sv
// Position/speed tracker fed by the quadrature direction decoder.
// Define ENCODER_POS_SATURATE_EN to clamp pos at its limits instead of wrapping.
module encoder_position
  import encoder_pkg::*;
#(
  parameter int POS_W     = 16,
  parameter int VEL_W     = 12,
  parameter int WINDOW    = 1000,
  parameter int STALL_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              dir,
  input  logic                    clear,
  input  logic                    err_clr,
  output logic signed [POS_W-1:0] pos,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid,
  output logic [1:0]              motion,
  output logic                    err
);

  localparam int IDLE_W = (STALL_CYC > 2) ? $clog2(STALL_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(STALL_CYC - 1);

  logic signed [1:0]       w_step;
  logic                    w_ill;
  logic signed [POS_W:0]   w_pos_sum;
  logic signed [POS_W-1:0] w_pos_next;
  logic signed [POS_W-1:0] r_pos;
  logic                    r_err;
  motion_t                 r_motion;
  logic [IDLE_W-1:0]       r_idle;

  assign w_step    = dir_to_step(dir);
  assign w_ill     = (dir == DIR_ILL);
  assign w_pos_sum = {r_pos[POS_W-1], r_pos} + {{(POS_W-1){w_step[1]}}, w_step};

`ifdef ENCODER_POS_SATURATE_EN
  // A unit step can only overshoot by one, so dropping it equals clamping.
  assign w_pos_next = (w_pos_sum[POS_W] != w_pos_sum[POS_W-1]) ? r_pos
                                                               : w_pos_sum[POS_W-1:0];
`else
  assign w_pos_next = w_pos_sum[POS_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_err <= 1'b0;
    end else begin
      r_pos <= clear ? '0 : w_pos_next;
      if (w_ill)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;
    end
  end

  // Motion FSM: any step re-arms the stall timer; reversal skips STOPPED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_motion <= STOPPED;
      r_idle   <= '0;
    end else begin
      case (dir)
        DIR_FWD: begin
          r_motion <= FWD;
          r_idle   <= '0;
        end
        DIR_REV: begin
          r_motion <= REV;
          r_idle   <= '0;
        end
        default: begin
          if (r_idle == IDLE_LAST)
            r_motion <= STOPPED;
          else
            r_idle <= r_idle + 1'b1;
        end
      endcase
    end
  end

  enc_vel_window #(
    .VEL_W  (VEL_W),
    .WINDOW (WINDOW)
  ) u_vel_window (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (w_step),
    .vel       (vel),
    .vel_valid (vel_valid)
  );

  assign pos    = r_pos;
  assign motion = r_motion;
  assign err    = r_err;

endmodule

// File: tb/tb_encoder_position.sv
// Directed self-checking bench for encoder_position (WINDOW=10, STALL_CYC=8),
// plus a narrow-velocity instance for accumulator saturation.
module tb_encoder_position;

  localparam logic [1:0] D_NONE = 2'b00;
  localparam logic [1:0] D_REV  = 2'b01;
  localparam logic [1:0] D_FWD  = 2'b10;
  localparam logic [1:0] D_ILL  = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] dir = D_NONE;
  logic [1:0] dir2 = D_NONE;
  logic clear = 1'b0;
  logic err_clr = 1'b0;

  logic signed [15:0] pos;
  logic signed [11:0] vel;
  logic               vel_valid;
  logic [1:0]         motion;
  logic               err;

  logic signed [15:0] pos2;
  logic signed [2:0]  vel2;
  logic               vel_valid2;
  logic [1:0]         motion2;
  logic               err2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  encoder_position #(.POS_W(16), .VEL_W(12), .WINDOW(10), .STALL_CYC(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .dir(dir), .clear(clear), .err_clr(err_clr),
    .pos(pos), .vel(vel), .vel_valid(vel_valid), .motion(motion), .err(err)
  );

  encoder_position #(.POS_W(16), .VEL_W(3), .WINDOW(10), .STALL_CYC(8)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .dir(dir2), .clear(1'b0), .err_clr(1'b0),
    .pos(pos2), .vel(vel2), .vel_valid(vel_valid2), .motion(motion2), .err(err2)
  );

  // Called at a negedge; returns at the next negedge with outputs of that edge.
  task automatic cyc(input logic [1:0] d, input logic [1:0] d2, input logic c, input logic e);
    dir = d; dir2 = d2; clear = c; err_clr = e;
    @(posedge clk);
    @(negedge clk);
    dir = D_NONE; dir2 = D_NONE; clear = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (pos !== 16'sd0) begin $display("FAIL reset_pos got=%0d exp=0", pos); n_errors++; end
    n_checks++; if (vel !== 12'sd0) begin $display("FAIL reset_vel got=%0d exp=0", vel); n_errors++; end
    n_checks++; if (vel_valid !== 1'b0) begin $display("FAIL reset_vel_valid got=%b exp=0", vel_valid); n_errors++; end
    n_checks++; if (motion !== 2'b00) begin $display("FAIL reset_motion got=%b exp=00", motion); n_errors++; end
    n_checks++; if (err !== 1'b0) begin $display("FAIL reset_err got=%b exp=0", err); n_errors++; end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    n_checks++; if (pos !== 16'sd1) begin $display("FAIL basic_pos1 got=%0d exp=1", pos); n_errors++; end
    for (int i = 0; i < 4; i++) cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    n_checks++; if (pos !== 16'sd5) begin $display("FAIL basic_pos5 got=%0d exp=5", pos); n_errors++; end
    n_checks++; if (motion !== 2'b01) begin $display("FAIL basic_motion got=%b exp=01", motion); n_errors++; end
    n_checks++; if (err !== 1'b0) begin $display("FAIL basic_err got=%b exp=0", err); n_errors++; end
  endtask

  task automatic test_window();
    do_reset();
    for (int i = 0; i < 6; i++) cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    n_checks++; if (vel_valid !== 1'b0 || vel !== 12'sd0) begin
      $display("FAIL win_pre got vel=%0d valid=%b exp vel=0 valid=0", vel, vel_valid); n_errors++; end
    cyc(D_REV, D_NONE, 1'b0, 1'b0);
    n_checks++; if (vel !== 12'sd2) begin $display("FAIL win_vel got=%0d exp=2", vel); n_errors++; end
    n_checks++; if (vel_valid !== 1'b1) begin $display("FAIL win_valid got=%b exp=1", vel_valid); n_errors++; end
    cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    n_checks++; if (vel_valid !== 1'b0 || vel !== 12'sd2) begin
      $display("FAIL win_pulse_width got vel=%0d valid=%b exp vel=2 valid=0", vel, vel_valid); n_errors++; end
    for (int i = 0; i < 8; i++) cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    n_checks++; if (vel_valid !== 1'b0) begin $display("FAIL win_gap_valid got=%b exp=0", vel_valid); n_errors++; end
    cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    n_checks++; if (vel !== 12'sd0 || vel_valid !== 1'b1) begin
      $display("FAIL win_idle got vel=%0d valid=%b exp vel=0 valid=1", vel, vel_valid); n_errors++; end
  endtask

  task automatic test_vel_sat();
    do_reset();
    for (int i = 0; i < 10; i++) cyc(D_NONE, D_FWD, 1'b0, 1'b0);
    n_checks++; if (vel2 !== 3'sd3 || vel_valid2 !== 1'b1) begin
      $display("FAIL vsat_pos got vel=%0d valid=%b exp vel=3 valid=1", vel2, vel_valid2); n_errors++; end
    n_checks++; if (pos2 !== 16'sd10 || motion2 !== 2'b01 || err2 !== 1'b0) begin
      $display("FAIL vsat_pos2 got pos=%0d motion=%b err=%b exp pos=10 motion=01 err=0", pos2, motion2, err2); n_errors++; end
    for (int i = 0; i < 10; i++) cyc(D_NONE, D_REV, 1'b0, 1'b0);
    n_checks++; if (vel2 !== -3'sd4) begin $display("FAIL vsat_neg got=%0d exp=-4", vel2); n_errors++; end
    for (int i = 0; i < 7; i++) cyc(D_NONE, D_FWD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(D_NONE, D_REV, 1'b0, 1'b0);
    n_checks++; if (vel2 !== 3'sd0) begin $display("FAIL vsat_clamped_acc got=%0d exp=0", vel2); n_errors++; end
  endtask

  task automatic test_pos_limit();
    logic signed [15:0] exp_up;
    logic signed [15:0] exp_dn;
`ifdef ENCODER_POS_SATURATE_EN
    exp_up = 16'sh7FFF;
    exp_dn = 16'sh7FFE;
`else
    exp_up = 16'sh8000;
    exp_dn = 16'sh7FFF;
`endif
    do_reset();
    for (int i = 0; i < 32767; i++) cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    n_checks++; if (pos !== 16'sh7FFF) begin $display("FAIL lim_max got=%0d exp=32767", pos); n_errors++; end
    cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    n_checks++; if (pos !== exp_up) begin $display("FAIL lim_over got=%0d exp=%0d", pos, exp_up); n_errors++; end
    cyc(D_REV, D_NONE, 1'b0, 1'b0);
    n_checks++; if (pos !== exp_dn) begin $display("FAIL lim_back got=%0d exp=%0d", pos, exp_dn); n_errors++; end
  endtask

  task automatic test_err();
    do_reset();
    cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    cyc(D_ILL, D_NONE, 1'b0, 1'b0);
    n_checks++; if (err !== 1'b1) begin $display("FAIL err_set got=%b exp=1", err); n_errors++; end
    n_checks++; if (pos !== 16'sd2 || motion !== 2'b01) begin
      $display("FAIL err_pos got pos=%0d motion=%b exp pos=2 motion=01", pos, motion); n_errors++; end
    cyc(D_ILL, D_NONE, 1'b0, 1'b1);
    n_checks++; if (err !== 1'b1) begin $display("FAIL err_set_wins got=%b exp=1", err); n_errors++; end
    cyc(D_NONE, D_NONE, 1'b0, 1'b1);
    n_checks++; if (err !== 1'b0) begin $display("FAIL err_clr got=%b exp=0", err); n_errors++; end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 7; i++) cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    n_checks++; if (pos !== 16'sd7) begin $display("FAIL clr_pre got=%0d exp=7", pos); n_errors++; end
    cyc(D_FWD, D_NONE, 1'b1, 1'b0);
    n_checks++; if (pos !== 16'sd0) begin $display("FAIL clr_pos got=%0d exp=0", pos); n_errors++; end
    cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    n_checks++; if (vel !== 12'sd8 || vel_valid !== 1'b1) begin
      $display("FAIL clr_vel got vel=%0d valid=%b exp vel=8 valid=1", vel, vel_valid); n_errors++; end
  endtask

  task automatic test_motion();
    do_reset();
    cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    n_checks++; if (motion !== 2'b01) begin $display("FAIL mot_fwd got=%b exp=01", motion); n_errors++; end
    cyc(D_REV, D_NONE, 1'b0, 1'b0);
    n_checks++; if (motion !== 2'b10) begin $display("FAIL mot_rev got=%b exp=10", motion); n_errors++; end
    for (int i = 0; i < 7; i++) cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    n_checks++; if (motion !== 2'b10) begin $display("FAIL mot_hold got=%b exp=10", motion); n_errors++; end
    cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    n_checks++; if (motion !== 2'b00) begin $display("FAIL mot_stall got=%b exp=00", motion); n_errors++; end
    for (int i = 0; i < 10; i++) cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    n_checks++; if (vel !== 12'sd10 || motion !== 2'b01) begin
      $display("FAIL mot_vel got vel=%0d motion=%b exp vel=10 motion=01", vel, motion); n_errors++; end
    for (int i = 0; i < 3; i++) cyc(D_FWD, D_NONE, 1'b0, 1'b0);
    n_checks++; if (pos !== 16'sd13) begin $display("FAIL mot_pos got=%0d exp=13", pos); n_errors++; end
    rst_n = 1'b0;
    #1;
    n_checks++; if (pos !== 16'sd0 || vel !== 12'sd0 || vel_valid !== 1'b0 || motion !== 2'b00 || err !== 1'b0) begin
      $display("FAIL async_rst got pos=%0d vel=%0d valid=%b motion=%b err=%b exp all 0",
               pos, vel, vel_valid, motion, err); n_errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    n_checks++; if (vel_valid !== 1'b0) begin $display("FAIL rst_win_early got=%b exp=0", vel_valid); n_errors++; end
    cyc(D_NONE, D_NONE, 1'b0, 1'b0);
    n_checks++; if (vel !== 12'sd0 || vel_valid !== 1'b1) begin
      $display("FAIL rst_win got vel=%0d valid=%b exp vel=0 valid=1", vel, vel_valid); n_errors++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window();
    test_vel_sat();
    test_err();
    test_clear();
    test_motion();
    test_pos_limit();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encoder_position.md
# encoder_position

Position and speed tracker that sits directly downstream of the quadrature direction decoder. It consumes the per-cycle `dir` step code and keeps a signed position count. It measures signed velocity as steps per fixed sample window and classifies motion as stopped, forward or reverse. Its outputs feed the control/display logic of the encoder design.

## Interface
Parameters:
- POS_W, 16: position counter width, signed two's complement
- VEL_W, 12: velocity output width, signed
- WINDOW, 1000: velocity sample window length in clk cycles (≥2)
- STALL_CYC, 50000: cycles without a step before motion returns to STOPPED (≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- dir  in  2  step code from decoder: 2'b10 = +1, 2'b01 = −1, 2'b00 = none, 2'b11 = illegal
- clear  in  1  synchronous zero of position, one-cycle strobe
- err_clr  in  1  clears sticky error flag
- pos  out  POS_W  signed position count
- vel  out  VEL_W  signed steps counted in last completed window
- vel_valid  out  1  one-cycle pulse when vel updates
- motion  out  2  2'b00 STOPPED, 2'b01 FWD, 2'b10 REV
- err  out  1  sticky: illegal dir code seen

## Operation
- Reset values: pos=0, vel=0, vel_valid=0, motion=STOPPED, err=0. Internal window counter, window accumulator and idle counter also reset to 0.
- Step decode: +1, −1 or 0 from dir. 2'b11 gives step 0 and sets err.
- Position: pos ← pos + step each cycle. clear has priority over a same-cycle step, so pos becomes 0 and that step is discarded. Overflow behaviour is set by Configuration.
- Velocity window: the counter runs 0..WINDOW−1 and wraps. The accumulator adds each step, saturating at ±(2^(VEL_W−1)−1) / −2^(VEL_W−1).
  - In the cycle where the counter is WINDOW−1: vel ← sat(acc + step), acc ← 0, vel_valid asserted on the next cycle.
  - The step in that terminal cycle belongs to the closing window.
  - clear does not affect the window, acc or vel.
- Motion FSM:
  - STOPPED/FWD/REV, on step +1 → FWD; on step −1 → REV. Either step zeroes the idle counter.
  - Reversal moves FWD↔REV directly, with no pass through STOPPED.
  - With no step (including illegal), the idle counter increments. When it reaches STALL_CYC−1 the next state is STOPPED and the counter holds.
- err: set by 2'b11; cleared by err_clr. Set wins when both occur in the same cycle.

## Timing
- All outputs registered. pos, motion and err reflect a dir value one clock after the edge that samples it.
- vel_valid: first pulse is high in the cycle after rising edge number WINDOW after reset release. Subsequent pulses follow every WINDOW cycles and are exactly one cycle wide.
- Motion drops to STOPPED STALL_CYC cycles after the last step.
- Reset mid-window discards the partial accumulation. The next window starts at count 0 on the first edge after release.
- dir is assumed already synchronous to clk; no synchronizer in this block.

## Configuration
- ENCODER_POS_SATURATE_EN defined: pos clamps at 2^(POS_W−1)−1 and −2^(POS_W−1); steps beyond a limit are dropped.
- Not defined: pos wraps modulo 2^POS_W (max +1 → min, min −1 → max).
- Velocity saturation is unconditional.

## Structure
- Shared package encoder_pkg holds:
  - dir code constants: DIR_FWD=2'b10, DIR_REV=2'b01, DIR_NONE=2'b00, DIR_ILL=2'b11
  - motion state typedef/encodings: STOPPED, FWD, REV
- One sub-module, enc_vel_window: window counter, saturating accumulator, vel/vel_valid registers. Its parameters are VEL_W and WINDOW, its input is step, and its outputs are vel and vel_valid.
- Position counter, motion FSM and err live in the top.

## Test plan
- Reset, then 5 cycles of dir=2'b10 → pos=5 one cycle after the last; motion=FWD; err=0.
- WINDOW=10, with dir=2'b10 on 3 cycles and 2'b01 on 1 cycle within the first window, the last of these being the terminal cycle → vel=2, vel_valid one cycle wide at cycle 10. The next window with no steps → vel=0.
- Set pos to 32767 (POS_W=16), then apply one +1 step → 32767 with ENCODER_POS_SATURATE_EN defined, −32768 without it.
- dir=2'b11 → err=1, pos unchanged. Assert err_clr together with a second 2'b11 → err stays 1. err_clr alone → err=0.
- With pos=7, clear and dir=2'b10 in the same cycle → pos=0. The window accumulator still counts the step.
- STALL_CYC=8: steps +1 then −1 → motion FWD then REV directly. After 8 idle cycles → STOPPED. Asserting rst_n=0 mid-window → all outputs return to reset values asynchronously.
